// File: rtl/mcdf_ctrl_regs_n.sv
// MCDF control/status register file: per-channel CTRL (R/W) and STAT (RO) registers.
// Define MCDF_CTRL_ERR_EN to add the sticky ERR register, IRQ_MASK and err_irq_o.
module mcdf_ctrl_regs_n #(
    parameter int unsigned CH_NUM  = 3,
    parameter int unsigned AVAIL_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [1:0]                 cmd_i,
    input  logic [7:0]                 cmd_addr_i,
    input  logic [31:0]                cmd_data_i,
    output logic [31:0]                cmd_data_o,
    input  logic [CH_NUM*AVAIL_W-1:0]  slv_avail_i,
    output logic [CH_NUM-1:0]          slv_en_o,
    output logic [CH_NUM*2-1:0]        slv_prio_o,
    output logic [CH_NUM*3-1:0]        slv_len_o,
    output logic                       err_irq_o
);

    localparam logic [1:0] CmdRd = 2'b01;
    localparam logic [1:0] CmdWr = 2'b10;

    logic [CH_NUM-1:0]   en_q;
    logic [CH_NUM*2-1:0] prio_q;
    logic [CH_NUM*3-1:0] len_q;
    logic [31:0]         rdata_q;
    logic [31:0]         rd_val;

    logic       is_rd, is_wr;
    logic       aligned, idx_ok, is_ctrl, is_stat, is_err, is_mask, legal;
    logic [3:0] idx;

    assign is_rd   = (cmd_i == CmdRd);
    assign is_wr   = (cmd_i == CmdWr);
    assign aligned = (cmd_addr_i[1:0] == 2'b00);
    assign idx     = cmd_addr_i[5:2];
    assign idx_ok  = (32'(idx) < CH_NUM);
    assign is_ctrl = aligned && (cmd_addr_i[7:6] == 2'b00) && idx_ok;
    assign is_stat = aligned && (cmd_addr_i[7:6] == 2'b01) && idx_ok;
`ifdef MCDF_CTRL_ERR_EN
    assign is_err  = (cmd_addr_i == 8'h80);
    assign is_mask = (cmd_addr_i == 8'h84);
`else
    assign is_err  = 1'b0;
    assign is_mask = 1'b0;
`endif
    assign legal   = is_ctrl || is_stat || is_err || is_mask;

`ifdef MCDF_CTRL_ERR_EN
    logic [1:0] err_q, err_d, mask_q;
    logic       irq_q;
`endif

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < int'(CH_NUM); c++) begin
            if (is_ctrl && idx == 4'(c)) begin
                rd_val[5:0] = {len_q[c*3 +: 3], prio_q[c*2 +: 2], en_q[c]};
            end
            if (is_stat && idx == 4'(c)) begin
                rd_val[AVAIL_W-1:0] = slv_avail_i[c*AVAIL_W +: AVAIL_W];
            end
        end
`ifdef MCDF_CTRL_ERR_EN
        if (is_err)  rd_val[1:0] = err_q;
        if (is_mask) rd_val[1:0] = mask_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q    <= {CH_NUM{1'b1}};
            prio_q  <= '0;
            len_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (is_rd) rdata_q <= rd_val;
            for (int c = 0; c < int'(CH_NUM); c++) begin
                if (is_wr && is_ctrl && idx == 4'(c)) begin
                    en_q[c]          <= cmd_data_i[0];
                    prio_q[c*2 +: 2] <= cmd_data_i[2:1];
                    len_q[c*3 +: 3]  <= cmd_data_i[5:3];
                end
            end
        end
    end

`ifdef MCDF_CTRL_ERR_EN
    // Clear is applied before set so a fresh error in the same cycle wins over W1C.
    always_comb begin
        err_d = err_q;
        if (is_wr && is_err) err_d = err_d & ~cmd_data_i[1:0];
        if ((is_rd || is_wr) && !legal) err_d[0] = 1'b1;
        if (is_wr && is_stat) err_d[1] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q  <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            if (is_wr && is_mask) mask_q <= cmd_data_i[1:0];
            irq_q <= |(err_q & mask_q);
        end
    end

    assign err_irq_o = irq_q;
`else
    assign err_irq_o = 1'b0;
`endif

    assign cmd_data_o = rdata_q;
    assign slv_en_o   = en_q;
    assign slv_prio_o = prio_q;
    assign slv_len_o  = len_q;

endmodule
